// File: rtl/seven_segment_pkg.sv
// Shared constants for the four-digit seven-segment driver: active-low hex glyphs
// (bit order gfedcba) and the "all dark" patterns for segments and digit enables.
package seven_segment_pkg;

  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [3:0] EN_OFF  = 4'hF;

  localparam logic [6:0] GLYPHS [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30,
    7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03,
    7'h46, 7'h21, 7'h06, 7'h0E
  };

  function automatic logic [6:0] hex_glyph(input logic [3:0] value);
    return GLYPHS[value];
  endfunction

endpackage

// File: rtl/single_pulser.sv
// Converts a push-button level into a single one-clock pulse per rising edge.
// Both sync stages reset high so a button held through reset produces no pulse.
module single_pulser (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic s1_reg;
  logic s2_reg;
  logic q_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_reg <= 1'b1;
      s2_reg <= 1'b1;
      q_reg  <= 1'b0;
    end else begin
      s1_reg <= d;
      s2_reg <= s1_reg;
      q_reg  <= s1_reg & ~s2_reg;
    end
  end

  assign q = q_reg;

endmodule

// File: rtl/seven_segment.sv
// Time-multiplexed four-digit hex driver for a common-anode display.
// The top two refresh-counter bits pick the digit; enables and glyph register together.
module seven_segment
  import seven_segment_pkg::*;
#(
  parameter int REFRESH_BITS = 18
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       blank,
  input  logic [3:0] digit3,
  input  logic [3:0] digit2,
  input  logic [3:0] digit1,
  input  logic [3:0] digit0,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       d,
  output logic       e,
  output logic       f,
  output logic       g,
  output logic       numsl0,
  output logic       numsl1,
  output logic       numsl2,
  output logic       numsl3
);

  logic [REFRESH_BITS-1:0] cnt_reg;
  logic [1:0]              sel;
  logic [3:0]              digits [4];
  logic [3:0]              en_next;
  logic [6:0]              seg_next;
  logic [3:0]              en_reg;
  logic [6:0]              seg_reg;

  assign sel       = cnt_reg[REFRESH_BITS-1 -: 2];
  assign digits[0] = digit0;
  assign digits[1] = digit1;
  assign digits[2] = digit2;
  assign digits[3] = digit3;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_enable
      assign en_next[gi] = (sel != 2'(gi));
    end
  endgenerate

  always_comb begin
    seg_next = hex_glyph(digits[sel]);
    if (blank) begin
      seg_next = SEG_OFF;
    end
  end

  // Enable and glyph share one register stage, so a digit switch never shows a stale glyph.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_reg <= '0;
      en_reg  <= EN_OFF;
      seg_reg <= SEG_OFF;
    end else begin
      cnt_reg <= cnt_reg + REFRESH_BITS'(1);
      en_reg  <= en_next;
      seg_reg <= seg_next;
    end
  end

  assign {g, f, e, d, c, b, a}            = seg_reg;
  assign {numsl3, numsl2, numsl1, numsl0} = en_reg;

endmodule

// File: tb/tb_seven_segment.sv
// Directed bench for seven_segment (REFRESH_BITS = 4) and single_pulser; a reference
// model pushes expected {enables, segments} at each edge and the sample after it pops them.
module tb_seven_segment;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       blank;
  logic [3:0] digit3, digit2, digit1, digit0;
  logic       sa, sb, sc, sd, se, sf, sg;
  logic       numsl0, numsl1, numsl2, numsl3;
  logic       p_d, p_q;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int pulses = 0;
  int first_pulse = -1;
  logic [3:0] mcnt = 4'd0;
  logic [10:0] exp_q [$];

  string lit_tab [16] = '{"abcdef", "bc", "abdeg", "abcdg",
                          "bcfg", "acdfg", "acdefg", "abc",
                          "abcdefg", "abcdfg", "abcefg", "cdefg",
                          "adef", "bcdeg", "adefg", "aefg"};

  always #5 clk = ~clk;

  seven_segment #(.REFRESH_BITS(4)) dut (
    .clk(clk), .rst_n(rst_n), .blank(blank),
    .digit3(digit3), .digit2(digit2), .digit1(digit1), .digit0(digit0),
    .a(sa), .b(sb), .c(sc), .d(sd), .e(se), .f(sf), .g(sg),
    .numsl0(numsl0), .numsl1(numsl1), .numsl2(numsl2), .numsl3(numsl3)
  );

  single_pulser u_pulser (.clk(clk), .rst_n(rst_n), .d(p_d), .q(p_q));

  // Active-low {g..a} vector built from the list of lit segment letters.
  function automatic logic [6:0] lit2seg(input string s);
    logic [6:0] r = 7'h7F;
    for (int i = 0; i < s.len(); i++) r[int'(s.getc(i)) - 97] = 1'b0;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  task automatic step();
    logic [3:0] digs [4];
    logic [3:0] en;
    logic [6:0] seg;
    logic [10:0] got, want;
    @(posedge clk);
    digs[0] = digit0; digs[1] = digit1; digs[2] = digit2; digs[3] = digit3;
    if (!rst_n) begin
      exp_q.push_back({4'hF, 7'h7F});
      mcnt = 4'd0;
    end else begin
      en = 4'hF;
      en[mcnt[3:2]] = 1'b0;
      seg = blank ? 7'h7F : lit2seg(lit_tab[digs[mcnt[3:2]]]);
      exp_q.push_back({en, seg});
      mcnt = mcnt + 4'd1;
    end
    #1;
    cyc++;
    got  = {numsl3, numsl2, numsl1, numsl0, sg, sf, se, sd, sc, sb, sa};
    want = exp_q.pop_front();
    chk("enables", 32'(got[10:7]), 32'(want[10:7]));
    chk("segments", 32'(got[6:0]), 32'(want[6:0]));
    $display("cycle %0d rst_n=%b blank=%b en=%b seg=%b exp_en=%b exp_seg=%b q=%b",
             cyc, rst_n, blank, got[10:7], got[6:0], want[10:7], want[6:0], p_q);
    if (p_q) begin
      pulses++;
      if (first_pulse < 0) first_pulse = cyc;
    end
  endtask

  initial begin
    int k;
    int guard;
    rst_n = 1'b0; blank = 1'b0; p_d = 1'b1;
    digit3 = 4'd4; digit2 = 4'd3; digit1 = 4'd2; digit0 = 4'd5;

    // Reset for two clocks with the button already held.
    step(); step();
    chk("reset_dark", 32'({numsl3, numsl2, numsl1, numsl0, sg, sf, se, sd, sc, sb, sa}), 32'h7FF);
    rst_n = 1'b1;
    step();
    chk("first_digit_numsl0", 32'({numsl3, numsl2, numsl1, numsl0}), 32'b1110);
    chk("first_glyph_5", 32'({sg, sf, se, sd, sc, sb, sa}), 32'(lit2seg("acdfg")));
    for (int i = 0; i < 16; i++) step();   // full frame plus wrap back to numsl0
    chk("held_through_reset_no_pulse", 32'(pulses), 32'd0);

    // Button press held for 10 clocks: one pulse, two edges after first sampled high.
    p_d = 1'b0;
    for (int i = 0; i < 3; i++) step();
    p_d = 1'b1;
    k = cyc + 1;
    for (int i = 0; i < 10; i++) step();
    chk("long_press_pulses", 32'(pulses), 32'd1);
    chk("pulse_latency", 32'(first_pulse), 32'(k + 1));
    p_d = 1'b0;
    for (int i = 0; i < 3; i++) step();
    p_d = 1'b1;
    for (int i = 0; i < 3; i++) step();
    p_d = 1'b0;
    step(); step();
    chk("two_presses_pulses", 32'(pulses), 32'd2);

    // Full decode sweep on digit0, one frame per value.
    for (int v = 0; v < 16; v++) begin
      digit0 = 4'(v);
      for (int i = 0; i < 16; i++) step();
    end

    // Blank mid-frame, then resume.
    for (int i = 0; i < 5; i++) step();
    blank = 1'b1;
    for (int i = 0; i < 7; i++) step();
    blank = 1'b0;
    for (int i = 0; i < 4; i++) step();

    // Reset while numsl2 is active.
    guard = 0;
    while (numsl2 !== 1'b0 && guard < 20) begin
      step();
      guard++;
    end
    chk("found_numsl2", 32'(numsl2), 32'd0);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    chk("after_midscan_reset_numsl0", 32'({numsl3, numsl2, numsl1, numsl0}), 32'b1110);

    // Digit update latency: 1 -> 7 while numsl0 is active.
    digit0 = 4'd1;
    step();
    chk("latency_before", 32'({sg, sf, se, sd, sc, sb, sa}), 32'(lit2seg("bc")));
    digit0 = 4'd7;
    step();
    chk("latency_after", 32'({sg, sf, se, sd, sc, sb, sa}), 32'(lit2seg("abc")));
    for (int i = 0; i < 8; i++) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
